pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the fixed 8-bit PC register.
- Sits at the front of the fetch stage and drives instruction-memory address requests with a valid/ready handshake.
- Adds stall, branch/jump redirect, halt/resume, wrap-around and misalignment reporting.
- Feeds the fetch stage; takes redirects from the execute stage and stalls from the hazard unit.

Parameters:
- PC_WIDTH, 32, width of PC and targets in bits (min 4)
- RESET_VECTOR, 0, PC value loaded on reset (PC_WIDTH bits)
- INSTR_BYTES, 4, sequential increment; power of two, 2 or 4

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hold PC; no sequential advance
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_target  in  PC_WIDTH  redirect destination
- halt_req  in  1  request fetch halt
- resume  in  1  leave HALT
- fetch_ready  in  1  imem accepts pc_out this cycle
- pc_out  out  PC_WIDTH  registered fetch address
- pc_valid  out  1  pc_out is a live request
- pc_next  out  PC_WIDTH  combinational value pc_out takes next edge
- halted  out  1  high while in HALT
- misalign_err  out  1  one-cycle pulse, misaligned redirect target

Behaviour:
- Reset (rst_n low at edge, overrides everything):
  - pc_out=RESET_VECTOR, pc_valid=0, halted=0, misalign_err=0, state=BOOT.
- States:
  - BOOT: exactly one cycle with pc_valid=0, then RUN (pc_valid=1, pc_out=RESET_VECTOR).
  - RUN: pc_valid=1.
  - HALT: pc_valid=0, halted=1.
- Next-PC priority in RUN (high to low):
  1. redirect_valid: pc <= target with low log2(INSTR_BYTES) bits cleared.
  2. stall: hold.
  3. fetch_ready: pc <= pc+INSTR_BYTES.
  4. Otherwise: hold.
- Accept = pc_valid && fetch_ready && !stall. Advance on accept only; latency 1 cycle.
- Increment wraps modulo 2^PC_WIDTH (all-ones-aligned + INSTR_BYTES -> 0). No error is raised on wrap.
- Handshake stability: while pc_valid && !fetch_ready, pc_out is stable unless redirect_valid. A redirect withdraws the outstanding request (flush semantics).
- misalign_err pulses high the cycle after a redirect whose target has nonzero low bits. The redirect still completes.
- halt_req in RUN: next state HALT, pc held. With a simultaneous redirect, the PC takes the target and still enters HALT.
- In HALT:
  - Redirect updates pc_out; state stays HALT.
  - resume && !halt_req -> RUN. halt_req wins over resume.
- Redirect in BOOT: pc loads the target; BOOT still completes its single cycle.
- pc_next always equals the value pc_out holds after the coming edge, including during reset (RESET_VECTOR).

Optional Feature:
- Macro: PC_GEN_TRAP_VECTOR_EN.
- Defined:
  - Adds parameter TRAP_VECTOR (default 'h100), input trap_req, output epc [PC_WIDTH].
  - trap_req is highest priority in every non-reset state: pc <= TRAP_VECTOR, epc <= current pc_out, state <= RUN (exits HALT and BOOT).
  - epc resets to 0.
- Undefined: trap_req, epc and TRAP_VECTOR do not exist; no trap logic is synthesised.

Decomposition:
- Shared package pc_gen_pkg:
  - state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2)
  - default INSTR_BYTES
  - alignment-mask helper function
- One sub-module, pc_next_sel: combinational priority mux (trap/redirect/stall/increment, alignment masking) producing pc_next and misalign detect.
- pc_gen holds the FSM and registers.

Test Plan (PC_WIDTH=8, RESET_VECTOR=8'h10, INSTR_BYTES=4):
- Reset, then fetch_ready=1 constantly -> one cycle pc_valid=0; then pc_out 10,14,18,1C on consecutive cycles.
- fetch_ready=0 for 3 cycles at pc=14 -> pc_out stays 14, pc_valid=1; fetch_ready=1 -> 18 next cycle.
- Wrap:
  - redirect_target=8'hFC -> pc=FC, then 00, 04.
  - Redirect to 8'h23 with stall=1 -> pc=20, misalign_err=1 for exactly one cycle.
- halt_req with simultaneous redirect to 40 -> pc_out=40, halted=1, pc_valid=0.
  - halt_req+resume together -> stays HALT.
  - resume alone -> RUN at 40.
- rst_n low mid-stall at pc=30 -> next edge pc_out=10, pc_valid=0, halted=0.
- With PC_GEN_TRAP_VECTOR_EN, TRAP_VECTOR=8'h80: trap_req in HALT at pc=24 -> pc_out=80, epc=24, RUN.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared definitions for the program-counter generator.
//   - pc_state_e          : FSM state encoding (BOOT / RUN / HALT)
//   - DEFAULT_INSTR_BYTES : default sequential increment
//   - align_mask()        : mask that clears the instruction-offset bits
// Optional feature macro used by the users of this package: PC_GEN_TRAP_VECTOR_EN.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam int unsigned DEFAULT_INSTR_BYTES = 4;

    // Returns a 64-bit mask with the low log2(instr_bytes) bits cleared;
    // callers truncate to their PC width. instr_bytes must be a power of two.
    function automatic logic [63:0] align_mask(input int unsigned instr_bytes);
        return ~(64'(instr_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-address request channel between the PC generator and imem.
//   pc_out      : registered fetch address
//   pc_valid    : pc_out is a live request
//   pc_next     : value pc_out takes on the coming edge
//   fetch_ready : imem accepts pc_out this cycle
// Modports: master (PC generator side), slave (instruction-memory side).
interface pc_gen_if #(
    parameter int PC_WIDTH = 32
);
    logic [PC_WIDTH-1:0] pc_out;
    logic                pc_valid;
    logic [PC_WIDTH-1:0] pc_next;
    logic                fetch_ready;

    modport master (output pc_out, output pc_valid, output pc_next, input fetch_ready);
    modport slave  (input pc_out, input pc_valid, input pc_next, output fetch_ready);
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority mux.
//   Priority: reset > trap (optional) > redirect > sequential increment > hold.
//   Redirect targets are aligned down to INSTR_BYTES; misalign flags a redirect
//   whose target had nonzero offset bits (registered by the caller).
// Ports: rst_n, state, pc, stall, halt_req, fetch_ready, redirect_valid,
//   redirect_target, [trap_req], pc_next, misalign.
// Optional feature macro: PC_GEN_TRAP_VECTOR_EN (adds trap_req / TRAP_VECTOR).
module pc_next_sel
    import pc_gen_pkg::*;
#(
    parameter int                   PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
`ifdef PC_GEN_TRAP_VECTOR_EN
    parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = PC_WIDTH'('h100),
`endif
    parameter int unsigned          INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
    input  logic                rst_n,
    input  pc_state_e           state,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                stall,
    input  logic                halt_req,
    input  logic                fetch_ready,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
`ifdef PC_GEN_TRAP_VECTOR_EN
    input  logic                trap_req,
`endif
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                misalign
);

    localparam logic [PC_WIDTH-1:0] MASK = PC_WIDTH'(align_mask(INSTR_BYTES));
    localparam logic [PC_WIDTH-1:0] INCR = PC_WIDTH'(INSTR_BYTES);

    logic [PC_WIDTH-1:0] target_aligned;
    logic                target_low_nz;

    assign target_aligned = redirect_target & MASK;
    assign target_low_nz  = |(redirect_target & ~MASK);

    always_comb begin
        pc_next  = pc;
        misalign = 1'b0;
        if (!rst_n) begin
            pc_next = RESET_VECTOR;
`ifdef PC_GEN_TRAP_VECTOR_EN
        end else if (trap_req) begin
            pc_next = TRAP_VECTOR;
`endif
        end else if (redirect_valid) begin
            // Redirect flushes any outstanding request, so it beats stall.
            pc_next  = target_aligned;
            misalign = target_low_nz;
        end else if (state == ST_RUN && fetch_ready && !stall && !halt_req) begin
            // Accepted request; a pending halt freezes the PC instead so that
            // fetch restarts at the same address on resume. Wraps naturally.
            pc_next = pc + INCR;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: parametrised program-counter generator at the front of fetch.
//   Drives fetch addresses over a valid/ready channel, with stall, redirect,
//   halt/resume, wrap-around and misaligned-redirect reporting.
// Ports:
//   clk, rst_n (synchronous, active low)
//   stall, redirect_valid, redirect_target, halt_req, resume : control inputs
//   fetch (pc_gen_if.master) : pc_out, pc_valid, pc_next, fetch_ready
//   halted, misalign_err : status outputs
//   trap_req, epc : only with PC_GEN_TRAP_VECTOR_EN defined
// Optional feature macro: PC_GEN_TRAP_VECTOR_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                   PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
`ifdef PC_GEN_TRAP_VECTOR_EN
    parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = PC_WIDTH'('h100),
`endif
    parameter int unsigned          INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    input  logic                halt_req,
    input  logic                resume,
`ifdef PC_GEN_TRAP_VECTOR_EN
    input  logic                trap_req,
    output logic [PC_WIDTH-1:0] epc,
`endif
    pc_gen_if.master            fetch,
    output logic                halted,
    output logic                misalign_err
);

    pc_state_e           state;
    logic [PC_WIDTH-1:0] pc;
    logic                pc_valid_q;
    logic [PC_WIDTH-1:0] pc_next;
    logic                misalign;

    pc_next_sel #(
        .PC_WIDTH     (PC_WIDTH),
        .RESET_VECTOR (RESET_VECTOR),
`ifdef PC_GEN_TRAP_VECTOR_EN
        .TRAP_VECTOR  (TRAP_VECTOR),
`endif
        .INSTR_BYTES  (INSTR_BYTES)
    ) u_sel (
        .rst_n           (rst_n),
        .state           (state),
        .pc              (pc),
        .stall           (stall),
        .halt_req        (halt_req),
        .fetch_ready     (fetch.fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
`ifdef PC_GEN_TRAP_VECTOR_EN
        .trap_req        (trap_req),
`endif
        .pc_next         (pc_next),
        .misalign        (misalign)
    );

    // PC register, FSM and registered status outputs in one process.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_BOOT;
            pc           <= RESET_VECTOR;
            pc_valid_q   <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
`ifdef PC_GEN_TRAP_VECTOR_EN
            epc          <= '0;
`endif
        end else begin
            pc           <= pc_next;
            misalign_err <= misalign;
`ifdef PC_GEN_TRAP_VECTOR_EN
            if (trap_req) begin
                epc        <= pc;
                state      <= ST_RUN;
                pc_valid_q <= 1'b1;
                halted     <= 1'b0;
            end else
`endif
            case (state)
                ST_BOOT: begin
                    // Single idle cycle after reset, even if redirected.
                    state      <= ST_RUN;
                    pc_valid_q <= 1'b1;
                    halted     <= 1'b0;
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state      <= ST_HALT;
                        pc_valid_q <= 1'b0;
                        halted     <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (resume && !halt_req) begin
                        state      <= ST_RUN;
                        pc_valid_q <= 1'b1;
                        halted     <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_BOOT;
                    pc_valid_q <= 1'b0;
                    halted     <= 1'b0;
                end
            endcase
        end
    end

    assign fetch.pc_out   = pc;
    assign fetch.pc_valid = pc_valid_q;
    assign fetch.pc_next  = pc_next;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen (PC_WIDTH=8, RESET_VECTOR=8'h10,
// INSTR_BYTES=4). A behavioural model tracks mode/pc with plain integer
// arithmetic; a negedge process compares every output against it, and the
// stimulus sequence also pins hand-computed literal values.
// Optional feature macro: PC_GEN_TRAP_VECTOR_EN (TRAP_VECTOR=8'h80).
module tb_pc_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall;
    logic       redirect_valid;
    logic [7:0] redirect_target;
    logic       halt_req;
    logic       resume;
    logic       halted;
    logic       misalign_err;
    logic       trap_req;
`ifdef PC_GEN_TRAP_VECTOR_EN
    logic [7:0] epc;
`endif

    pc_gen_if #(.PC_WIDTH(8)) fif ();

    pc_gen #(
        .PC_WIDTH     (8),
        .RESET_VECTOR (8'h10),
`ifdef PC_GEN_TRAP_VECTOR_EN
        .TRAP_VECTOR  (8'h80),
`endif
        .INSTR_BYTES  (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .resume          (resume),
`ifdef PC_GEN_TRAP_VECTOR_EN
        .trap_req        (trap_req),
        .epc             (epc),
`endif
        .fetch           (fif),
        .halted          (halted),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: "B" boot, "R" running, "H" halted
    int  m_pc    = 0;
    int  m_epc   = 0;
    byte m_mode  = "B";
    bit  m_mis   = 0;
    bit  m_known = 0;

    function automatic void model_next(output int npc, output int nepc,
                                       output byte nmode, output bit nmis);
        int t;
        t     = int'(redirect_target);
        npc   = m_pc;
        nepc  = m_epc;
        nmode = m_mode;
        nmis  = 0;
        if (!rst_n) begin
            npc = 'h10; nepc = 0; nmode = "B";
            return;
        end
`ifdef PC_GEN_TRAP_VECTOR_EN
        if (trap_req) begin
            nepc = m_pc; npc = 'h80; nmode = "R";
            return;
        end
`endif
        if (redirect_valid) begin
            npc  = t - (t % 4);
            nmis = (t % 4) != 0;
        end else if (m_mode == "R" && fif.fetch_ready && !stall && !halt_req) begin
            npc = (m_pc + 4) % 256;
        end
        if (m_mode == "B")
            nmode = "R";
        else if (m_mode == "R")
            nmode = halt_req ? "H" : "R";
        else
            nmode = (resume && !halt_req) ? "R" : "H";
    endfunction

    always @(posedge clk) begin
        int  npc, nepc;
        byte nmode;
        bit  nmis;
        if (m_known || !rst_n) begin
            model_next(npc, nepc, nmode, nmis);
            m_pc = npc; m_epc = nepc; m_mode = nmode; m_mis = nmis;
            m_known = 1;
        end
    end

    // Single compare process: outputs are stable mid-cycle.
    always @(negedge clk) begin
        int  npc, nepc;
        byte nmode;
        bit  nmis;
        if (m_known) begin
            model_next(npc, nepc, nmode, nmis);
            chk("pc_next",      32'(fif.pc_next),  32'(npc));
            chk("pc_out",       32'(fif.pc_out),   32'(m_pc));
            chk("pc_valid",     32'(fif.pc_valid), 32'(m_mode == "R"));
            chk("halted",       32'(halted),       32'(m_mode == "H"));
            chk("misalign_err", 32'(misalign_err), 32'(m_mis));
`ifdef PC_GEN_TRAP_VECTOR_EN
            chk("epc",          32'(epc),          32'(m_epc));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 0; stall = 0; redirect_valid = 0; redirect_target = 8'h00;
        halt_req = 0; resume = 0; trap_req = 0; fif.fetch_ready = 1;
        tick(); tick();
        chk("rst pc_out",   32'(fif.pc_out),   32'h10);
        chk("rst pc_valid", 32'(fif.pc_valid), 32'h0);
        chk("rst halted",   32'(halted),       32'h0);
        chk("rst misalign", 32'(misalign_err), 32'h0);

        // Boot cycle then sequential fetch
        rst_n = 1;
        tick(); chk("run0 pc", 32'(fif.pc_out), 32'h10); chk("run0 valid", 32'(fif.pc_valid), 32'h1);
        tick(); chk("run1 pc", 32'(fif.pc_out), 32'h14);
        tick(); chk("run2 pc", 32'(fif.pc_out), 32'h18);
        tick(); chk("run3 pc", 32'(fif.pc_out), 32'h1C);

        // Back-pressure at 14
        redirect_valid = 1; redirect_target = 8'h14;
        tick(); chk("redir14 pc", 32'(fif.pc_out), 32'h14);
        redirect_valid = 0; fif.fetch_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold pc",    32'(fif.pc_out),   32'h14);
            chk("hold valid", 32'(fif.pc_valid), 32'h1);
        end
        fif.fetch_ready = 1;
        tick(); chk("release pc", 32'(fif.pc_out), 32'h18);

        // Wrap-around
        redirect_valid = 1; redirect_target = 8'hFC;
        tick(); chk("wrap FC", 32'(fif.pc_out), 32'hFC);
        redirect_valid = 0;
        tick(); chk("wrap 00", 32'(fif.pc_out), 32'h00);
        tick(); chk("wrap 04", 32'(fif.pc_out), 32'h04);

        // Misaligned redirect under stall
        stall = 1; redirect_valid = 1; redirect_target = 8'h23;
        tick(); chk("mis pc", 32'(fif.pc_out), 32'h20); chk("mis pulse", 32'(misalign_err), 32'h1);
        redirect_valid = 0;
        tick(); chk("mis hold", 32'(fif.pc_out), 32'h20); chk("mis clear", 32'(misalign_err), 32'h0);
        stall = 0;

        // Halt with simultaneous redirect
        halt_req = 1; redirect_valid = 1; redirect_target = 8'h40;
        tick();
        chk("halt pc",    32'(fif.pc_out),   32'h40);
        chk("halt flag",  32'(halted),       32'h1);
        chk("halt valid", 32'(fif.pc_valid), 32'h0);
        redirect_valid = 0; resume = 1;
        tick(); chk("halt wins", 32'(halted), 32'h1);
        halt_req = 0;
        tick();
        chk("resume valid", 32'(fif.pc_valid), 32'h1);
        chk("resume pc",    32'(fif.pc_out),   32'h40);
        resume = 0;
        tick(); chk("resume adv", 32'(fif.pc_out), 32'h44);

        // Reset mid-stall at 30
        redirect_valid = 1; redirect_target = 8'h30;
        tick();
        redirect_valid = 0; stall = 1;
        tick(); chk("stall 30", 32'(fif.pc_out), 32'h30);
        rst_n = 0;
        tick();
        chk("rst2 pc",     32'(fif.pc_out),   32'h10);
        chk("rst2 valid",  32'(fif.pc_valid), 32'h0);
        chk("rst2 halted", 32'(halted),       32'h0);
        rst_n = 1; stall = 0;
        tick(); chk("rst2 run", 32'(fif.pc_valid), 32'h1);

`ifdef PC_GEN_TRAP_VECTOR_EN
        // Trap out of HALT
        halt_req = 1; redirect_valid = 1; redirect_target = 8'h24;
        tick(); chk("trap pre pc", 32'(fif.pc_out), 32'h24); chk("trap pre halt", 32'(halted), 32'h1);
        halt_req = 0; redirect_valid = 0; trap_req = 1;
        tick();
        chk("trap pc",    32'(fif.pc_out),   32'h80);
        chk("trap epc",   32'(epc),          32'h24);
        chk("trap valid", 32'(fif.pc_valid), 32'h1);
        trap_req = 0;
        tick(); chk("trap adv", 32'(fif.pc_out), 32'h84);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
